// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg                                                              |
// | Shared AluOp codes, op classification helpers and the sequencer      |
// | FSM state encoding.                                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_OR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Codes 011 and 100 have no meaning for the cell.
  function automatic logic op_is_legal(input logic [2:0] code);
    return (code != 3'b011) && (code != 3'b100);
  endfunction

  // Only ADD and SUB propagate a carry between bit slices.
  function automatic logic op_is_arith(input logic [2:0] code);
    return (code == OP_ADD) || (code == OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ALU                                                                  |
// | 1-bit ALU cell: ADD, SUB (a + ~b + cin), AND, OR, NOR, XOR.          |
// | Carry out is only meaningful for ADD/SUB and is 0 otherwise.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ALU
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] alu_op,
  output logic       r,
  output logic       cout
);

  logic b_inv;

  assign b_inv = ~b;

  // Per-op bit function; illegal codes produce 0.
  always_comb begin
    r    = 1'b0;
    cout = 1'b0;
    case (alu_op)
      OP_ADD: begin
        r    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
      OP_SUB: begin
        r    = a ^ b_inv ^ cin;
        cout = (a & b_inv) | (a & cin) | (b_inv & cin);
      end
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      default: begin
        r    = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/serial_alu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_alu_ctrl                                                      |
// | Bit-serial sequencer: steps the 1-bit ALU cell once per clock, LSB   |
// | first, to produce a WIDTH-bit result with carry, zero and error.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [2:0]       op_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             cell_r;
  logic             cell_cout;
  logic             accept;
  logic             legal;
  logic             last_bit;
  logic [WIDTH-1:0] result_next;

  assign accept      = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign legal       = op_is_legal(op);
  assign last_bit    = (cnt == LAST_BIT);
  assign result_next = {cell_r, result[WIDTH-1:1]};

  ALU u_alu (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .cin    (carry),
    .alu_op (op_q),
    .r      (cell_r),
    .cout   (cell_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; illegal ops skip RUN and report immediately.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = legal ? ST_RUN : ST_DONE;
      ST_RUN:  if (last_bit) next_state = ST_DONE;
      ST_DONE: begin
        if (start) next_state = legal ? ST_RUN : ST_DONE;
        else       next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state == ST_RUN);
      done <= (next_state == ST_DONE);
    end
  end

  // Operand capture, per-bit shifting and final flag loading.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      op_q   <= 3'b000;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else if (accept) begin
      result <= '0;
      cout   <= 1'b0;
      if (legal) begin
        a_sr  <= a_in;
        b_sr  <= b_in;
        op_q  <= op;
        // SUB is a + ~b + 1: the +1 enters as carry into bit 0.
        carry <= (op == OP_SUB);
        cnt   <= '0;
        zero  <= 1'b0;
        err   <= 1'b0;
      end else begin
        zero  <= 1'b1;
        err   <= 1'b1;
      end
    end else if (state == ST_RUN) begin
      result <= result_next;
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= op_is_arith(op_q) ? cell_cout : 1'b0;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        cout <= op_is_arith(op_q) ? cell_cout : 1'b0;
        zero <= (result_next == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_alu_ctrl                                                   |
// | Scoreboard bench for serial_alu_ctrl at WIDTH=8.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_serial_alu_ctrl;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             z;
    logic             e;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             err;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;
  int   busy_cycles;
  int   cyc;

  serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it differs.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of a whole WIDTH-bit operation.
  function automatic exp_t model(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t       m;
    logic [WIDTH:0] s;
    m = '0;
    s = '0;
    case (o)
      3'b000: begin s = {1'b0, a} + {1'b0, b};          m.res = s[WIDTH-1:0]; m.co = s[WIDTH]; end
      3'b010: begin s = {1'b0, a} + {1'b0, ~b} + 1'b1;  m.res = s[WIDTH-1:0]; m.co = s[WIDTH]; end
      3'b001: m.res = a ^ b;
      3'b101: m.res = ~(a | b);
      3'b110: m.res = a & b;
      3'b111: m.res = a | b;
      default: m.e = 1'b1;
    endcase
    m.z = (m.res == '0);
    return m;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (busy) busy_cycles++;
  endtask

  // Called at a negedge: presents a request and records its expected outcome.
  task automatic launch(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    sb.push_back(model(o, a, b));
    busy_cycles = 0;
    cyc = 0;
  endtask

  // Runs until done (bounded) and checks timing plus the scoreboard entry.
  task automatic wait_done(input string tag, input int exp_busy, input int exp_cyc);
    exp_t e;
    while (!done && cyc < 40) tick();
    check_eq({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    check_eq({tag, "_latency"}, cyc, exp_cyc);
    check_eq({tag, "_busy_cycles"}, busy_cycles, exp_busy);
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq({tag, "_result"}, {24'd0, result}, {24'd0, e.res});
      check_eq({tag, "_cout"}, {31'd0, cout}, {31'd0, e.co});
      check_eq({tag, "_zero"}, {31'd0, zero}, {31'd0, e.z});
      check_eq({tag, "_err"}, {31'd0, err}, {31'd0, e.e});
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic lg;
    lg = !(o == 3'b011 || o == 3'b100);
    @(negedge clk);
    launch(o, a, b);
    tick();
    start = 1'b0;
    wait_done(tag, lg ? WIDTH : 0, lg ? WIDTH + 1 : 1);
  endtask

  initial begin
    exp_t dropped;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_result", {24'd0, result}, 32'd0);
    check_eq("rst_flags", {29'd0, cout, zero, err}, 32'd0);
    rst_n = 1'b1;

    run_op("add_7f_01", 3'b000, 8'h7F, 8'h01);
    run_op("sub_7_5",   3'b010, 8'h07, 8'h05);
    run_op("sub_5_7",   3'b010, 8'h05, 8'h07);
    run_op("add_ff_01", 3'b000, 8'hFF, 8'h01);
    run_op("and",       3'b110, 8'hF0, 8'h3C);
    run_op("or",        3'b111, 8'hF0, 8'h0F);
    run_op("nor",       3'b101, 8'h00, 8'h00);
    run_op("xor",       3'b001, 8'hAA, 8'hAA);
    run_op("add_rand",  3'b000, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    run_op("sub_rand",  3'b010, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    // start pulsed mid-RUN must not disturb the running op.
    @(negedge clk);
    launch(3'b000, 8'h12, 8'h34);
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    op    = 3'b110;
    a_in  = 8'hFF;
    b_in  = 8'h00;
    tick();
    start = 1'b0;
    wait_done("midrun_ignored", WIDTH, WIDTH + 1);

    // Back-to-back: request presented during the DONE cycle.
    launch(3'b010, 8'h40, 8'h01);
    tick();
    start = 1'b0;
    check_eq("b2b_busy_next", {31'd0, busy}, 32'd1);
    wait_done("b2b", WIDTH, WIDTH + 1);

    // Illegal op, then a legal op clears err.
    run_op("illegal_011", 3'b011, 8'h55, 8'h22);
    check_eq("illegal_done_is_pulse_pre", {31'd0, busy}, 32'd0);
    @(negedge clk);
    launch(3'b000, 8'h01, 8'h01);
    tick();
    start = 1'b0;
    check_eq("err_cleared_on_accept", {31'd0, err}, 32'd0);
    wait_done("after_illegal", WIDTH, WIDTH + 1);
    run_op("illegal_100", 3'b100, 8'h00, 8'h00);

    // Reset in RUN cycle 4 aborts without done.
    @(negedge clk);
    launch(3'b000, 8'hAB, 8'hCD);
    tick();
    start = 1'b0;
    while (cyc < 4) tick();
    rst_n = 1'b0;
    tick();
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_result", {24'd0, result}, 32'd0);
    check_eq("abort_flags", {29'd0, cout, zero, err}, 32'd0);
    rst_n = 1'b1;
    dropped = sb.pop_front();
    repeat (3) tick();
    check_eq("abort_no_done", {31'd0, done}, 32'd0);
    run_op("post_reset_add", 3'b000, 8'h01, 8'h02);

    check_eq("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
